// File: rtl/hazard_unit.sv
// Hazard unit for the 16-bit five-stage pipeline: load-use bubbles, taken-branch
// flushes and shared-memory freezes, plus a saturating stall-cycle counter.
module hazard_unit #(
    parameter int REG_W        = 3,
    parameter int RX_LSB       = 8,
    parameter int RY_LSB       = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             HU_clk,
    input  logic             HU_rst,
    input  logic [15:0]      HU_instruction,
    input  logic             HU_rxUsed,
    input  logic             HU_ryUsed,
    input  logic [1:0]       HU_memRead_IDEX,
    input  logic [REG_W-1:0] HU_Rx_IDEX,
    input  logic [REG_W-1:0] HU_Ry_IDEX,
    input  logic             HU_branchTaken_EX,
    input  logic             HU_memBusy,
    output logic             HU_PCWrite,
    output logic             HU_IFIDWrite,
    output logic             HU_addBubble,
    output logic             HU_IFIDFlush,
    output logic             HU_pipeHold,
    output logic [CNT_W-1:0] HU_stallCount
);

    typedef enum logic {
        IDLE,
        LOAD_STALL
    } state_t;

    localparam logic [2:0]       BUBBLES_M1 = 3'(LOAD_BUBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state_q, state_d;
    logic [2:0]       bub_cnt_q, bub_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [REG_W-1:0] rx_id, ry_id;
    logic [REG_W-1:0] load_dest;
    logic             load_dest_valid;
    logic             load_use;
    logic             stall_req;

    assign rx_id = HU_instruction[RX_LSB +: REG_W];
    assign ry_id = HU_instruction[RY_LSB +: REG_W];

    // LW writes Ry, LWSP writes Rx; the other two codes are not loads.
    always_comb begin
        load_dest       = '0;
        load_dest_valid = 1'b0;
        unique case (HU_memRead_IDEX)
            2'b01: begin
                load_dest       = HU_Ry_IDEX;
                load_dest_valid = 1'b1;
            end
            2'b10: begin
                load_dest       = HU_Rx_IDEX;
                load_dest_valid = 1'b1;
            end
            default: begin
                load_dest       = '0;
                load_dest_valid = 1'b0;
            end
        endcase
    end

    assign load_use = load_dest_valid &&
                      ((HU_rxUsed && (load_dest == rx_id)) ||
                       (HU_ryUsed && (load_dest == ry_id)));

    // Once in LOAD_STALL, ID/EX already holds a bubble, so the IDEX inputs are ignored.
    assign stall_req = (state_q == LOAD_STALL) || load_use;

    always_ff @(posedge HU_clk or negedge HU_rst) begin
        if (!HU_rst) begin
            state_q     <= IDLE;
            bub_cnt_q   <= 3'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bub_cnt_q   <= bub_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bub_cnt_d = bub_cnt_q;
        if (HU_memBusy) begin
            state_d   = state_q;
            bub_cnt_d = bub_cnt_q;
        end else if (HU_branchTaken_EX) begin
            state_d   = IDLE;
            bub_cnt_d = 3'd0;
        end else if (state_q == LOAD_STALL) begin
            if (bub_cnt_q == 3'd1) begin
                state_d   = IDLE;
                bub_cnt_d = 3'd0;
            end else begin
                bub_cnt_d = bub_cnt_q - 3'd1;
            end
        end else if (load_use && (LOAD_BUBBLES > 1)) begin
            state_d   = LOAD_STALL;
            bub_cnt_d = BUBBLES_M1;
        end
    end

    // Reset forces a frozen pipeline; otherwise memBusy > branch > load stall > normal.
    always_comb begin
        HU_PCWrite   = 1'b1;
        HU_IFIDWrite = 1'b1;
        HU_addBubble = 1'b0;
        HU_IFIDFlush = 1'b0;
        HU_pipeHold  = 1'b0;
        if (!HU_rst || HU_memBusy) begin
            HU_PCWrite   = 1'b0;
            HU_IFIDWrite = 1'b0;
            HU_pipeHold  = 1'b1;
        end else if (HU_branchTaken_EX) begin
            HU_IFIDFlush = 1'b1;
            HU_addBubble = 1'b1;
        end else if (stall_req) begin
            HU_PCWrite   = 1'b0;
            HU_IFIDWrite = 1'b0;
            HU_addBubble = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!HU_PCWrite && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign HU_stallCount = stall_cnt_q;

endmodule
